// File: rtl/hat_man_sprite_fetch.sv
// Hat Man sprite fetch: ROM addressing, palette index capture and the hurt timer.
// Optional damage blink is compiled in with `define HURT_BLINK_EN.
module hat_man_sprite_fetch #(
  parameter int SPRITE_W     = 32,
  parameter int SPRITE_H     = 32,
  parameter int ADDR_W       = 10,
  parameter int TRANSP_IDX   = 1,
  parameter int HURT_FRAMES  = 30,
  parameter int BLINK_FRAMES = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_start,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        SpriteX,
  input  logic [9:0]        SpriteY,
  input  logic              hit,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_data,
  output logic [3:0]        index_out,
  output logic              sprite_on,
  output logic              hurt_sel,
  output logic              hurt_active
);

  localparam int LW = $clog2(SPRITE_W);
  localparam int CW = $clog2(HURT_FRAMES + 1);

  typedef enum logic {
    IDLE = 1'b0,
    HURT = 1'b1
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  logic signed [10:0] rel_x;
  logic signed [10:0] rel_y;
  logic               in_x;
  logic               in_y;
  logic               in_box;
  logic [ADDR_W-1:0]  addr_c;
  logic               box_d1;
  logic               box_d2;
  logic               visible;

  // Zero-extend before subtracting so left/above the sprite goes negative.
  assign rel_x = $signed({1'b0, DrawX}) - $signed({1'b0, SpriteX});
  assign rel_y = $signed({1'b0, DrawY}) - $signed({1'b0, SpriteY});

  assign in_x   = !rel_x[10] && ($unsigned(rel_x) < 11'(SPRITE_W));
  assign in_y   = !rel_y[10] && ($unsigned(rel_y) < 11'(SPRITE_H));
  assign in_box = in_x && in_y;
  assign addr_c = ADDR_W'({rel_y[9:0], rel_x[LW-1:0]});

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rom_addr  <= '0;
      box_d1    <= 1'b0;
      box_d2    <= 1'b0;
      index_out <= 4'd0;
      sprite_on <= 1'b0;
    end else begin
      rom_addr  <= in_box ? addr_c : '0;
      box_d1    <= in_box;
      box_d2    <= box_d1;
      index_out <= rom_data;
      sprite_on <= box_d2 && (rom_data != 4'(TRANSP_IDX)) && visible;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // A hit always reloads; the frame decrement only runs without one.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      IDLE: begin
        if (hit) begin
          state_next = HURT;
          cnt_next   = CW'(HURT_FRAMES);
        end
      end
      HURT: begin
        if (hit) begin
          cnt_next = CW'(HURT_FRAMES);
        end else if (frame_start) begin
          cnt_next = cnt - CW'(1);
          if (cnt == CW'(1)) state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    hurt_active = (state == HURT);
  end

  // Palette choice only changes at the frame boundary.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) hurt_sel <= 1'b0;
    else if (frame_start) hurt_sel <= hurt_active;
  end

`ifdef HURT_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BW-1:0] blink_cnt;
  logic          blink_vis;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      blink_cnt <= '0;
      blink_vis <= 1'b0;
    end else if (state == IDLE && state_next == HURT) begin
      blink_cnt <= '0;
      blink_vis <= 1'b0;
    end else if (state == HURT && frame_start) begin
      if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt <= '0;
        blink_vis <= ~blink_vis;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  assign visible = (state == HURT) ? blink_vis : 1'b1;
`else
  assign visible = 1'b1;
`endif

endmodule
